mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of writeback.
- Latches the execute-to-memory bundle and waits for the data SRAM read/write response when the instruction issued a request.
- Extracts and extends load data, and forwards the result bundle to writeback under a valid/allowin handshake.
- Tracks outstanding SRAM transactions so responses belonging to flushed instructions are discarded.

Parameters:
- EXCP_W, 86: width of the exception bundle passed through from execute to writeback unchanged.
- MAX_OUT, 2: maximum outstanding SRAM transactions tracked; the counter width is clog2(MAX_OUT+1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- EXE_signal_valid  in  1  execute stage presents a valid instruction.
- EXE_signal  in  77  {mem_req, ld_b, ld_bu, ld_h, ld_hu, ld_w, pc[31:0], res_from_mem, rf_we, rf_waddr[4:0], exe_result[31:0]}, MSB first.
- EXE_excep_signal  in  EXCP_W  exception bundle; bit 0 = "has exception or ertn".
- EXE_readygo  in  1  execute stage is ready to hand over.
- MEM_allowin  out  1  this stage can accept an instruction.
- data_sram_req_acc  in  1  execute-side req && addr_ok in this cycle.
- data_sram_data_ok  in  1  SRAM response strobe.
- data_sram_rdata  in  32  SRAM read data.
- WB_allowin  in  1  writeback can accept.
- WB_signal_valid  out  1  valid to writeback.
- WB_signal  out  70  {pc[31:0], rf_we, rf_waddr[4:0], final_result[31:0]}.
- WB_excep_signal  out  EXCP_W  registered exception bundle.
- MEM_flush  in  1  exception/ertn flush from writeback.
- MEM_to_EXE_excep  out  1  valid && registered bit 0 of the exception bundle.
- fwd_we  out  1  forwarding: valid && rf_we.
- fwd_waddr  out  5  forwarding destination register.
- fwd_wdata  out  32  forwarding: final_result.
- ld_MEM  out  1  valid && res_from_mem && !ms_readygo (load-use stall hint).

Behaviour:
- Reset values (asynchronous): ms_valid=0, the data register to 0, rdata_buf_valid=0, pend_cnt=0, cancel_cnt=0. All outputs follow from these: WB_signal_valid=0, fwd_we=0, ld_MEM=0.
- Accept: ms_valid <= EXE_signal_valid && EXE_readygo when MEM_allowin. The bundle and exception registers load on the same condition.
- MEM_flush has highest priority: ms_valid <= 0 that cycle, regardless of accept.
- pend_cnt tracks requests not yet answered: +1 on data_sram_req_acc, -1 on data_sram_data_ok; both in the same cycle leaves it unchanged. Saturation beyond MAX_OUT is a protocol error and its behaviour is undefined.
- On MEM_flush: cancel_cnt <= pend_cnt + data_sram_req_acc - data_sram_data_ok. This covers the flushed instruction's own request and any request execute had accepted that cycle.
- data_ok arriving while cancel_cnt>0 is dropped: cancel_cnt -= 1, and rdata_buf is not loaded.
- Otherwise, data_ok while ms_valid && mem_req && !rdata_buf_valid loads rdata_buf and sets rdata_buf_valid.
- rdata_buf_valid clears when the instruction leaves (ms_valid && ms_readygo && WB_allowin) or on flush.
- ms_readygo = !mem_req || rdata_buf_valid || (data_ok && cancel_cnt==0). Same-cycle data_ok is used combinationally.
- MEM_allowin = !ms_valid || (ms_readygo && WB_allowin).
- WB_signal_valid = ms_valid && ms_readygo && !MEM_flush.
- Load data is selected by byte offset exe_result[1:0]:
  - ld_b / ld_bu take the byte at that offset, sign- or zero-extended.
  - ld_h / ld_hu take the half at offset[1], sign- or zero-extended.
  - ld_w takes the full word.
- final_result = res_from_mem ? load data : exe_result.
- A store (mem_req=1, res_from_mem=0) still waits for data_ok. rf_we is 0 for stores, so final_result is irrelevant.
- Stall: if WB_allowin=0 when data_ok arrives, the data is held in rdata_buf until transfer. The SRAM bus is never asked to replay.
- Instructions with excep bit 0 set were not issued a request by execute (mem_req already cleared upstream). This stage does not wait on them.
- Latency: with no request, one cycle from acceptance to WB_signal_valid. With a request, WB_signal_valid is asserted in the same cycle data_ok arrives.

Test Plan:
- ALU op: pc=0x1c000000, rf_we=1, waddr=5, exe_result=0x1234, mem_req=0. Required: WB_signal_valid in the cycle after acceptance with final_result=0x1234; fwd_we=1, fwd_waddr=5.
- ld_b at addr 0x...03, rdata=0x80AABBCC, data_ok 3 cycles after acceptance. Required: ld_MEM=1 for 3 cycles, then final_result=0xFFFFFF80; ld_bu on the same data gives 0x00000080.
- ld_h at offset 2, rdata=0x7FFF0000, then ld_hu at offset 0 with rdata=0x0000FFFF. Required: final_result 0x00007FFF, then 0x0000FFFF.
- Load gets data_ok while WB_allowin=0 for 4 cycles. Required: rdata_buf holds the value, WB_signal_valid stays asserted, MEM_allowin=0, and the correct value transfers when WB_allowin=1.
- MEM_flush while a load is pending (pend_cnt=1) and execute accepts a request in the same cycle. Required: cancel_cnt=2, the next two data_ok are dropped, and the third data_ok completes the new load.
- Assert reset mid-wait. Required: ms_valid, pend_cnt and cancel_cnt are 0 immediately (asynchronously), and WB_signal_valid=0.

Source files
------------

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory-access pipeline stage between execute and writeback.
//
// The stage holds one instruction from execute. If that instruction issued a
// data SRAM request, the stage waits for the matching response. It then
// extracts and extends the load data and hands the result to writeback using
// a valid/allowin handshake.
//
// The stage also counts outstanding SRAM transactions. After a flush, the
// responses that still belong to killed instructions are recognised and
// thrown away.
//
// Parameters
//   EXCP_W   width of the exception bundle carried through unchanged
//   MAX_OUT  maximum number of SRAM transactions in flight
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   EXE_signal_valid    execute presents a valid instruction
//   EXE_signal          {mem_req, ld_b, ld_bu, ld_h, ld_hu, ld_w, pc[31:0],
//                        res_from_mem, rf_we, rf_waddr[4:0], exe_result[31:0]}
//   EXE_excep_signal    exception bundle, bit 0 = exception or ertn
//   EXE_readygo         execute is ready to hand over
//   MEM_allowin         this stage can accept an instruction
//   data_sram_req_acc   execute had a request accepted (req && addr_ok) now
//   data_sram_data_ok   SRAM response strobe
//   data_sram_rdata     SRAM read data
//   WB_allowin          writeback can accept
//   WB_signal_valid     result bundle valid towards writeback
//   WB_signal           {pc[31:0], rf_we, rf_waddr[4:0], final_result[31:0]}
//   WB_excep_signal     registered exception bundle
//   MEM_flush           exception/ertn flush coming back from writeback
//   MEM_to_EXE_excep    held instruction carries an exception or ertn
//   fwd_we/waddr/wdata  register-file forwarding path to decode
//   ld_MEM              a load is still waiting for its data (load-use hint)
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int EXCP_W  = 86,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EXE_signal_valid,
  input  logic [76:0]       EXE_signal,
  input  logic [EXCP_W-1:0] EXE_excep_signal,
  input  logic              EXE_readygo,
  output logic              MEM_allowin,
  input  logic              data_sram_req_acc,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  input  logic              WB_allowin,
  output logic              WB_signal_valid,
  output logic [69:0]       WB_signal,
  output logic [EXCP_W-1:0] WB_excep_signal,
  input  logic              MEM_flush,
  output logic              MEM_to_EXE_excep,
  output logic              fwd_we,
  output logic [4:0]        fwd_waddr,
  output logic [31:0]       fwd_wdata,
  output logic              ld_MEM
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  // Pipeline registers
  logic              ms_valid;
  logic [76:0]       ms_bundle;
  logic [EXCP_W-1:0] ms_excep;

  // Response holding buffer and transaction bookkeeping
  logic [31:0]       rdata_buf;
  logic              rdata_buf_valid;
  logic [CNT_W-1:0]  pend_cnt;
  logic [CNT_W-1:0]  cancel_cnt;
  logic [CNT_W-1:0]  pend_nxt;

  // Decoded fields of the held bundle
  logic        mem_req;
  logic        ld_b;
  logic        ld_bu;
  logic        ld_h;
  logic        ld_hu;
  logic        ld_w;
  logic [31:0] pc;
  logic        res_from_mem;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] exe_result;

  // Control
  logic        cancel_zero;
  logic        data_ok_live;
  logic        ms_readygo;
  logic        ms_leave;
  logic        ms_accept;
  logic        buf_load;

  // Datapath
  logic [31:0] load_word;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign mem_req      = ms_bundle[76];
  assign ld_b         = ms_bundle[75];
  assign ld_bu        = ms_bundle[74];
  assign ld_h         = ms_bundle[73];
  assign ld_hu        = ms_bundle[72];
  assign ld_w         = ms_bundle[71];
  assign pc           = ms_bundle[70:39];
  assign res_from_mem = ms_bundle[38];
  assign rf_we        = ms_bundle[37];
  assign rf_waddr     = ms_bundle[36:32];
  assign exe_result   = ms_bundle[31:0];

  // A response counts for the held instruction only when no killed
  // transaction is still ahead of it in the SRAM's response order.
  assign cancel_zero  = (cancel_cnt == '0);
  assign data_ok_live = data_sram_data_ok && cancel_zero;

  // A response arriving this cycle is used directly, so the result is valid
  // in the same cycle as data_ok without waiting for the buffer.
  assign ms_readygo  = !mem_req || rdata_buf_valid || data_ok_live;
  assign MEM_allowin = !ms_valid || (ms_readygo && WB_allowin);
  assign ms_leave    = ms_valid && ms_readygo && WB_allowin;
  assign ms_accept   = MEM_allowin && EXE_signal_valid && EXE_readygo;

  // The buffer captures only the first live response for the held request.
  // This lets a stalled writeback hold the data without the SRAM replaying it.
  assign buf_load = data_ok_live && ms_valid && mem_req && !rdata_buf_valid;

  assign pend_nxt = pend_cnt + CNT_W'(data_sram_req_acc) - CNT_W'(data_sram_data_ok);

  // Valid bit: a flush kills the held instruction even if a new one is offered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (MEM_flush) begin
      ms_valid <= 1'b0;
    end else if (MEM_allowin) begin
      ms_valid <= EXE_signal_valid && EXE_readygo;
    end
  end

  // Bundle and exception registers load with the instruction they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_bundle <= '0;
      ms_excep  <= '0;
    end else if (ms_accept) begin
      ms_bundle <= EXE_signal;
      ms_excep  <= EXE_excep_signal;
    end
  end

  // Count of requests accepted by the SRAM that have not yet been answered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_cnt <= '0;
    end else begin
      pend_cnt <= pend_nxt;
    end
  end

  // On a flush, every transaction still in flight becomes garbage. That
  // includes a request execute had accepted in the same cycle. These
  // responses are swallowed one by one as they return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cancel_cnt <= '0;
    end else if (MEM_flush) begin
      cancel_cnt <= pend_nxt;
    end else if (data_sram_data_ok && !cancel_zero) begin
      cancel_cnt <= cancel_cnt - CNT_W'(1);
    end
  end

  // Hold a response until the owning instruction moves on or is flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_buf_valid <= 1'b0;
      rdata_buf       <= '0;
    end else begin
      if (MEM_flush || ms_leave) begin
        rdata_buf_valid <= 1'b0;
      end else if (buf_load) begin
        rdata_buf_valid <= 1'b1;
      end
      if (buf_load) begin
        rdata_buf <= data_sram_rdata;
      end
    end
  end

  // Load data: select the byte or half by address offset, then extend it.
  always_comb begin
    load_word = rdata_buf_valid ? rdata_buf : data_sram_rdata;
    load_byte = 8'h00;
    load_half = load_word[15:0];
    load_data = 32'h0;
    case (exe_result[1:0])
      2'd0:    load_byte = load_word[7:0];
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase
    if (exe_result[1]) begin
      load_half = load_word[31:16];
    end
    if (ld_b) begin
      load_data = {{24{load_byte[7]}}, load_byte};
    end else if (ld_bu) begin
      load_data = {24'h0, load_byte};
    end else if (ld_h) begin
      load_data = {{16{load_half[15]}}, load_half};
    end else if (ld_hu) begin
      load_data = {16'h0, load_half};
    end else if (ld_w) begin
      load_data = load_word;
    end
  end

  assign final_result = res_from_mem ? load_data : exe_result;

  assign WB_signal_valid  = ms_valid && ms_readygo && !MEM_flush;
  assign WB_signal        = {pc, rf_we, rf_waddr, final_result};
  assign WB_excep_signal  = ms_excep;
  assign MEM_to_EXE_excep = ms_valid && ms_excep[0];

  assign fwd_we    = ms_valid && rf_we;
  assign fwd_waddr = rf_waddr;
  assign fwd_wdata = final_result;
  assign ld_MEM    = ms_valid && res_from_mem && !ms_readygo;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//
// Drives execute-side instructions and SRAM responses into mem_stage.
// Expected writeback bundles are queued when an instruction is issued. A
// separate monitor pops the queue and compares whenever the stage hands a
// result to writeback.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_stage;

  localparam int EXCP_W = 86;

  logic              clk;
  logic              reset;
  logic              EXE_signal_valid;
  logic [76:0]       EXE_signal;
  logic [EXCP_W-1:0] EXE_excep_signal;
  logic              EXE_readygo;
  logic              MEM_allowin;
  logic              data_sram_req_acc;
  logic              data_sram_data_ok;
  logic [31:0]       data_sram_rdata;
  logic              WB_allowin;
  logic              WB_signal_valid;
  logic [69:0]       WB_signal;
  logic [EXCP_W-1:0] WB_excep_signal;
  logic              MEM_flush;
  logic              MEM_to_EXE_excep;
  logic              fwd_we;
  logic [4:0]        fwd_waddr;
  logic [31:0]       fwd_wdata;
  logic              ld_MEM;

  typedef struct {
    logic [69:0]       sig;
    logic [EXCP_W-1:0] exc;
    bit                chk_result;
  } sb_entry_t;

  sb_entry_t exp_q[$];
  sb_entry_t mon_e;
  int checks = 0;
  int errors = 0;

  // Randomised transaction fields
  int          r_op;
  bit          r_exc0;
  logic [31:0] r_pc;
  logic        r_we;
  logic [4:0]  r_waddr;
  logic [31:0] r_addr;
  logic [31:0] r_rdata;
  int          r_delay;
  int          r_stall;

  mem_stage #(.EXCP_W(EXCP_W), .MAX_OUT(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .EXE_signal_valid  (EXE_signal_valid),
    .EXE_signal        (EXE_signal),
    .EXE_excep_signal  (EXE_excep_signal),
    .EXE_readygo       (EXE_readygo),
    .MEM_allowin       (MEM_allowin),
    .data_sram_req_acc (data_sram_req_acc),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .WB_allowin        (WB_allowin),
    .WB_signal_valid   (WB_signal_valid),
    .WB_signal         (WB_signal),
    .WB_excep_signal   (WB_excep_signal),
    .MEM_flush         (MEM_flush),
    .MEM_to_EXE_excep  (MEM_to_EXE_excep),
    .fwd_we            (fwd_we),
    .fwd_waddr         (fwd_waddr),
    .fwd_wdata         (fwd_wdata),
    .ld_MEM            (ld_MEM)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Op codes: 0 alu, 1 ld_b, 2 ld_bu, 3 ld_h, 4 ld_hu, 5 ld_w, 6 store
  function automatic bit is_load(input int op);
    return (op >= 1) && (op <= 5);
  endfunction

  function automatic bit uses_mem(input int op);
    return (op >= 1) && (op <= 6);
  endfunction

  // Reference load extraction: byte and half selection done arithmetically
  function automatic logic [31:0] ref_load(input int op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int unsigned off;
    logic [31:0] b;
    logic [31:0] h;
    off = int'(addr[1:0]);
    b = (rdata >> (8 * off)) & 32'hFF;
    h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
    case (op)
      1:       return (b >= 32'd128)   ? b - 32'd256   : b;
      2:       return b;
      3:       return (h >= 32'd32768) ? h - 32'd65536 : h;
      4:       return h;
      5:       return rdata;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [76:0] build_sig(input int op, input bit exc0,
                                            input logic [31:0] pc, input logic we,
                                            input logic [4:0] waddr,
                                            input logic [31:0] res);
    logic mreq;
    mreq = uses_mem(op) && !exc0;
    return {mreq, (op == 1), (op == 2), (op == 3), (op == 4), (op == 5),
            pc, is_load(op), we, waddr, res};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, actual, expected);
    end
  endtask

  // One instruction from acceptance to hand-over. The response arrives
  // 'delay' cycles after acceptance. Writeback refuses for the first
  // 'stall' cycles.
  task automatic applyStimulus(input int op, input bit exc0, input logic [31:0] pc,
                               input logic we, input logic [4:0] waddr,
                               input logic [31:0] addr, input logic [31:0] rdata,
                               input int delay, input int stall);
    logic [76:0]       sig;
    logic [EXCP_W-1:0] exc;
    logic [31:0]       fin;
    bit                mreq;
    bit                chk;
    int                r;
    sb_entry_t         e;
    sig  = build_sig(op, exc0, pc, we, waddr, addr);
    mreq = uses_mem(op) && !exc0;
    exc  = EXCP_W'({$urandom(), $urandom(), $urandom()});
    exc[0] = exc0;
    fin  = is_load(op) ? ref_load(op, addr, rdata) : addr;
    chk  = (op != 6) && !(is_load(op) && !mreq);
    r    = mreq ? delay + 1 : 1;
    e.sig = {pc, we, waddr, fin};
    e.exc = exc;
    e.chk_result = chk;
    exp_q.push_back(e);

    @(posedge clk); #1;
    EXE_signal_valid  = 1'b1;
    EXE_readygo       = 1'b1;
    EXE_signal        = sig;
    EXE_excep_signal  = exc;
    data_sram_req_acc = mreq;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = $urandom();
    WB_allowin        = 1'b1;
    @(negedge clk);
    checkOutput("accept_allowin", 128'(MEM_allowin), 128'(1'b1));

    for (int k = 1; k <= r + stall + 1; k++) begin
      @(posedge clk); #1;
      EXE_signal_valid  = 1'b0;
      EXE_signal        = 77'({$urandom(), $urandom(), $urandom()});
      data_sram_req_acc = 1'b0;
      WB_allowin        = (k > stall);
      data_sram_data_ok = mreq && (k == r);
      data_sram_rdata   = (mreq && (k == r)) ? rdata : $urandom();
      @(negedge clk);
      checkOutput("wb_valid", 128'(WB_signal_valid), 128'(k >= r));
      checkOutput("ld_MEM", 128'(ld_MEM), 128'(is_load(op) && mreq && (k < r)));
      checkOutput("mem_allowin", 128'(MEM_allowin), 128'((k >= r) && (k > stall)));
      checkOutput("fwd_we", 128'(fwd_we), 128'(we));
      checkOutput("fwd_waddr", 128'(fwd_waddr), 128'(waddr));
      checkOutput("excep_to_exe", 128'(MEM_to_EXE_excep), 128'(exc0));
      if (chk && (k >= r)) begin
        checkOutput("fwd_wdata", 128'(fwd_wdata), 128'(fin));
      end
      if ((k >= r) && (k > stall)) break;
    end
  endtask

  // Scoreboard monitor: every hand-over to writeback must match the oldest
  // expected entry.
  always @(negedge clk) begin
    if (!reset && WB_signal_valid && WB_allowin) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output got=%0h want=none", WB_signal);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wb_pc", 128'(WB_signal[69:38]), 128'(mon_e.sig[69:38]));
        checkOutput("wb_rf_we", 128'(WB_signal[37]), 128'(mon_e.sig[37]));
        checkOutput("wb_waddr", 128'(WB_signal[36:32]), 128'(mon_e.sig[36:32]));
        if (mon_e.chk_result) begin
          checkOutput("wb_result", 128'(WB_signal[31:0]), 128'(mon_e.sig[31:0]));
        end
        checkOutput("wb_excep", 128'(WB_excep_signal), 128'(mon_e.exc));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    sb_entry_t e;
    reset = 1'b1;
    EXE_signal_valid = 1'b0;
    EXE_signal = '0;
    EXE_excep_signal = '0;
    EXE_readygo = 1'b0;
    data_sram_req_acc = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    WB_allowin = 1'b1;
    MEM_flush = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_wb_valid", 128'(WB_signal_valid), 128'(1'b0));
    checkOutput("rst_fwd_we", 128'(fwd_we), 128'(1'b0));
    checkOutput("rst_ld_MEM", 128'(ld_MEM), 128'(1'b0));
    checkOutput("rst_allowin", 128'(MEM_allowin), 128'(1'b1));
    checkOutput("rst_excep", 128'(MEM_to_EXE_excep), 128'(1'b0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases
    applyStimulus(0, 0, 32'h1c000000, 1'b1, 5'd5, 32'h00001234, 32'h0, 0, 0);
    applyStimulus(1, 0, 32'h1c000004, 1'b1, 5'd7, 32'h00008003, 32'h80AABBCC, 3, 0);
    applyStimulus(2, 0, 32'h1c000008, 1'b1, 5'd8, 32'h00008003, 32'h80AABBCC, 3, 0);
    applyStimulus(3, 0, 32'h1c00000c, 1'b1, 5'd9, 32'h00008002, 32'h7FFF0000, 1, 0);
    applyStimulus(4, 0, 32'h1c000010, 1'b1, 5'd10, 32'h00008000, 32'h0000FFFF, 2, 0);
    applyStimulus(5, 0, 32'h1c000014, 1'b1, 5'd11, 32'h00000100, 32'hDEADBEEF, 0, 4);
    applyStimulus(6, 0, 32'h1c000018, 1'b0, 5'd0, 32'h00000200, 32'h0, 1, 0);
    applyStimulus(0, 1, 32'h1c00001c, 1'b1, 5'd12, 32'h00000abc, 32'h0, 0, 1);

    // Flush with one load pending and a same-cycle accepted request
    @(posedge clk); #1;
    WB_allowin = 1'b1;
    EXE_signal_valid = 1'b1;
    EXE_readygo = 1'b1;
    EXE_signal = build_sig(5, 0, 32'h1c000100, 1'b1, 5'd3, 32'h00003000);
    EXE_excep_signal = '0;
    data_sram_req_acc = 1'b1;
    @(posedge clk); #1;
    EXE_signal_valid = 1'b0;
    data_sram_req_acc = 1'b0;
    @(negedge clk);
    checkOutput("flush_pending_ld", 128'(ld_MEM), 128'(1'b1));
    @(posedge clk); #1;
    MEM_flush = 1'b1;
    data_sram_req_acc = 1'b1;
    @(negedge clk);
    checkOutput("flush_wb_valid", 128'(WB_signal_valid), 128'(1'b0));
    @(posedge clk); #1;
    MEM_flush = 1'b0;
    e.sig = {32'h1c000108, 1'b1, 5'd6, ref_load(1, 32'h00002001, 32'h0000F500)};
    e.exc = '0;
    e.chk_result = 1'b1;
    exp_q.push_back(e);
    EXE_signal_valid = 1'b1;
    EXE_signal = build_sig(1, 0, 32'h1c000108, 1'b1, 5'd6, 32'h00002001);
    data_sram_req_acc = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h11112211;
    @(negedge clk);
    checkOutput("flush_new_accept", 128'(MEM_allowin), 128'(1'b1));
    @(posedge clk); #1;
    EXE_signal_valid = 1'b0;
    data_sram_req_acc = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h00003300;
    @(negedge clk);
    checkOutput("drop2_wb_valid", 128'(WB_signal_valid), 128'(1'b0));
    checkOutput("drop2_ld_MEM", 128'(ld_MEM), 128'(1'b1));
    @(posedge clk); #1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0000F500;
    @(negedge clk);
    checkOutput("third_ok_wb_valid", 128'(WB_signal_valid), 128'(1'b1));
    checkOutput("third_ok_data", 128'(fwd_wdata), 128'(32'hFFFFFFF5));
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;

    // Asynchronous reset while a load waits behind a cancelled response
    @(posedge clk); #1;
    EXE_signal_valid = 1'b1;
    EXE_signal = build_sig(5, 0, 32'h1c000200, 1'b1, 5'd1, 32'h00004000);
    data_sram_req_acc = 1'b1;
    @(posedge clk); #1;
    EXE_signal_valid = 1'b0;
    data_sram_req_acc = 1'b0;
    MEM_flush = 1'b1;
    @(posedge clk); #1;
    MEM_flush = 1'b0;
    EXE_signal_valid = 1'b1;
    EXE_signal = build_sig(5, 0, 32'h1c000204, 1'b1, 5'd2, 32'h00004004);
    data_sram_req_acc = 1'b1;
    @(posedge clk); #1;
    EXE_signal_valid = 1'b0;
    data_sram_req_acc = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_ld_MEM", 128'(ld_MEM), 128'(1'b1));
    checkOutput("pre_rst_cancel", 128'(dut.cancel_cnt), 128'(1));
    checkOutput("pre_rst_pend", 128'(dut.pend_cnt), 128'(2));
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_ms_valid", 128'(dut.ms_valid), 128'(1'b0));
    checkOutput("async_rst_pend", 128'(dut.pend_cnt), 128'(0));
    checkOutput("async_rst_cancel", 128'(dut.cancel_cnt), 128'(0));
    checkOutput("async_rst_wb_valid", 128'(WB_signal_valid), 128'(1'b0));
    checkOutput("async_rst_ld_MEM", 128'(ld_MEM), 128'(1'b0));
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(3, 0, 32'h1c000300, 1'b1, 5'd4, 32'h00005002, 32'h8001AAAA, 1, 0);

    // Randomised traffic
    for (int i = 0; i < 80; i++) begin
      r_op    = int'($urandom_range(0, 6));
      r_exc0  = ($urandom_range(0, 7) == 0);
      r_pc    = $urandom() & 32'hFFFFFFFC;
      r_we    = (r_op == 6) ? 1'b0 : 1'($urandom_range(0, 1));
      r_waddr = 5'($urandom_range(0, 31));
      r_addr  = $urandom();
      r_rdata = $urandom();
      r_delay = int'($urandom_range(0, 3));
      r_stall = int'($urandom_range(0, 1)) * int'($urandom_range(0, 4));
      applyStimulus(r_op, r_exc0, r_pc, r_we, r_waddr, r_addr, r_rdata, r_delay, r_stall);
    end

    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
